inst_loader: RTL and testbench
==============================

# inst_loader

Debug-unit block that writes a program into the instruction memory one byte per strike. It takes a byte stream from the UART receiver, big-endian per 32-bit instruction, and drives the memory's byte-wide write port at consecutive addresses from 0. Loading stops when an assembled word equals the HALT instruction, or with an error when memory runs out. While loading, the memory's read side is idle.

## Interface
- `ENTRIES_SIZE`, 256, instruction memory depth in bytes.
- `DIR_ADDR_SIZE`, 8, memory write-address width; must satisfy 2^DIR_ADDR_SIZE ≥ ENTRIES_SIZE.
- `MEM_SIZE`, 8, memory data width (one byte).
- `HALT_WORD`, 32'hFFFF_FFFF, instruction that ends the program.
- `TIMEOUT_CYCLES`, 1_000_000, inter-byte timeout; used only when `INST_LOADER_TIMEOUT_EN` is defined.
- `i_clock` input 1: single clock; all logic on posedge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_start` input 1: one-cycle pulse that begins, or restarts, a load.
- `i_rx_data` input 8: received byte.
- `i_rx_valid` input 1: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_mem_enable` output 1: memory enable; high in LOAD.
- `o_mem_write_enable` output 1: one-cycle byte write strobe.
- `o_mem_write_data` output MEM_SIZE: byte to write.
- `o_mem_write_addr` output DIR_ADDR_SIZE: byte address.
- `o_byte_count` output DIR_ADDR_SIZE+1: bytes written in the current load.
- `o_busy` output 1: high in LOAD.
- `o_done` output 1: level, high in DONE.
- `o_error` output 1: level, high in ERROR.

## Operation
- States: IDLE, LOAD, DONE, ERROR. Reset enters IDLE.
- **Outputs in reset:** all outputs are 0. The word shift register, byte index (0..3) and address counter are also cleared.
- **IDLE:** `i_start` moves to LOAD. Address, byte count and byte index are cleared. `i_rx_valid` is ignored.
- **LOAD, on accepted byte (`i_rx_valid`):**
  - write the byte to the current address;
  - address +1, count +1;
  - shift the byte into the word (first byte goes to [31:24]);
  - byte index +1, mod 4.
- **HALT detection:** when the 4th byte of a word is accepted and the assembled word equals `HALT_WORD`, the block moves to DONE. The HALT bytes are written like any other, so the CPU sees the HALT instruction.
- **Overflow:** a byte that arrives when count == ENTRIES_SIZE is not written and the block moves to ERROR.
- **DONE / ERROR:** these states hold until `i_start`, which moves to LOAD with everything cleared. `i_rx_valid` is ignored.
- **Restart mid-load:** `i_start` in LOAD restarts at address 0 and discards the partial word.
- **Simultaneous `i_start` and `i_rx_valid`:** `i_start` wins and the byte is dropped, in every state.
- Address arithmetic is unsigned. The address never wraps, because the overflow check stops it at ENTRIES_SIZE.

## Timing
- All outputs are registered.
- `i_rx_valid` in cycle N gives `o_mem_write_enable` = 1 in cycle N+1, with that byte's data and address. The strobe is high for exactly one cycle per byte.
- `o_byte_count` updates in cycle N+1.
- After the last HALT byte, `o_done` and `o_busy` = 0 both take effect in cycle N+1, the same cycle as that byte's write strobe.
- `o_error` from overflow rises in cycle N+1, with no write.
- `i_start` in cycle N gives `o_busy` = 1 in cycle N+1.
- Back-to-back `i_rx_valid` on every cycle is supported at full rate.
- Asynchronous reset clears everything immediately, including mid-write. A write strobe in flight is cancelled.

## Configuration
- `INST_LOADER_TIMEOUT_EN` defined:
  - a cycle counter runs in LOAD;
  - it is cleared on LOAD entry and on every accepted byte;
  - reaching TIMEOUT_CYCLES moves to ERROR in the next cycle.
- Not defined: LOAD waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Structure
- **Shared package `loader_pkg`:**
  - state encoding constants (IDLE=2'd0, LOAD=2'd1, DONE=2'd2, ERROR=2'd3);
  - default `HALT_WORD`;
  - byte-index width.
- **Sub-module `inst_loader_timer`:**
  - a clear/enable counter with an expiry flag;
  - instantiated only under `INST_LOADER_TIMEOUT_EN`.

## Test plan
- **Reset:** hold `i_reset` mid-LOAD → all outputs 0 immediately; the state is IDLE after release.
- **Normal load:**
  - stimulus: `i_start`, then bytes 20,08,00,05, FF,FF,FF,FF;
  - required: 8 write strobes at addresses 0..7 with the same data;
  - `o_done` = 1 the cycle after the last byte, `o_byte_count` = 8.
- **Misaligned FF run:** bytes 00,FF,FF,FF, FF,00,00,00 → no DONE; byte count = 8; still busy.
- **Overflow:**
  - stimulus: 256 non-HALT bytes, then one more;
  - required: 256 writes at addresses 0..255;
  - the 257th byte produces no write, and `o_error` = 1.
- **Restart and priority:**
  - `i_start` after 3 bytes → the next byte is written at address 0 and count = 1;
  - `i_start` and `i_rx_valid` in the same cycle → the byte is dropped.
- **Timeout** (`INST_LOADER_TIMEOUT_EN`, TIMEOUT_CYCLES=16): `i_start`, then 1 byte, then silence → `o_error` = 1 after 16 idle cycles.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the instruction loader.
//   state_e            - loader FSM state encoding
//   HALT_WORD_DEFAULT  - instruction word that terminates a program
//   BYTE_IDX_W         - width of the byte-within-word index (4 bytes per word)
package loader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDone  = 2'd2,
        StError = 2'd3
    } state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int unsigned BYTE_IDX_W        = 2;

endpackage

// File: rtl/inst_loader_timer.sv
// inst_loader_timer: saturating cycle counter with synchronous clear and an
// expiry flag, used as the inter-byte watchdog of inst_loader.
//   i_clock   - clock, posedge
//   i_reset   - asynchronous active-high reset
//   i_clear   - restart the count from zero (wins over i_enable)
//   i_enable  - count one per cycle while high
//   o_expired - high while the count has reached LIMIT
module inst_loader_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_enable && (count_q != CNT_LIM)) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    assign o_expired = (count_q == CNT_LIM);

endmodule

// File: rtl/inst_loader.sv
// inst_loader: loads a program into instruction memory from a UART byte stream.
// Bytes arrive big-endian per 32-bit instruction and are written one per strobe
// at consecutive byte addresses from 0. Loading ends in DONE when a complete,
// aligned word equals HALT_WORD (the HALT bytes are still written), or in ERROR
// when a byte arrives with the memory already full.
//
// Optional feature: define INST_LOADER_TIMEOUT_EN to add an inter-byte watchdog
// that moves LOAD to ERROR after TIMEOUT_CYCLES cycles without a byte.
//
// Ports:
//   i_clock            - clock, posedge
//   i_reset            - asynchronous active-high reset
//   i_start            - pulse: begin or restart a load (wins over i_rx_valid)
//   i_rx_data          - received byte
//   i_rx_valid         - one-cycle strobe qualifying i_rx_data
//   o_mem_enable       - memory enable, high while loading
//   o_mem_write_enable - one-cycle byte write strobe
//   o_mem_write_data   - byte to write
//   o_mem_write_addr   - byte address of the write
//   o_byte_count       - bytes written in the current load
//   o_busy             - high while loading
//   o_done             - level, program ended with HALT
//   o_error            - level, overflow (or timeout)
module inst_loader
    import loader_pkg::*;
#(
    parameter int unsigned ENTRIES_SIZE   = 256,
    parameter int unsigned DIR_ADDR_SIZE  = 8,
    parameter int unsigned MEM_SIZE       = 8,
    parameter logic [31:0] HALT_WORD      = HALT_WORD_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_mem_enable,
    output logic                     o_mem_write_enable,
    output logic [MEM_SIZE-1:0]      o_mem_write_data,
    output logic [DIR_ADDR_SIZE-1:0] o_mem_write_addr,
    output logic [DIR_ADDR_SIZE:0]   o_byte_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error
);

    localparam logic [DIR_ADDR_SIZE:0] CNT_FULL = (DIR_ADDR_SIZE + 1)'(ENTRIES_SIZE);
    localparam logic [DIR_ADDR_SIZE:0] CNT_ONE  = (DIR_ADDR_SIZE + 1)'(1);
    localparam logic [BYTE_IDX_W-1:0]  IDX_ONE  = BYTE_IDX_W'(1);

    state_e                   state_q;
    // The byte count doubles as the next write address; it stops at
    // ENTRIES_SIZE, so its low bits never need to wrap.
    logic [DIR_ADDR_SIZE:0]   count_q;
    logic [BYTE_IDX_W-1:0]    idx_q;
    // Only the first three bytes of a word need holding; the fourth is
    // compared directly as it arrives.
    logic [23:0]              word_q;
    logic                     we_q;
    logic [MEM_SIZE-1:0]      wdata_q;
    logic [DIR_ADDR_SIZE-1:0] waddr_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     error_q;
    logic                     timeout;

`ifdef INST_LOADER_TIMEOUT_EN
    logic timer_clear;

    // Cleared outside LOAD (covers LOAD entry) and on every start/byte.
    assign timer_clear = (state_q != StLoad) || i_start || i_rx_valid;

    inst_loader_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (timer_clear),
        .i_enable  (state_q == StLoad),
        .o_expired (timeout)
    );
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            count_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (i_start) begin
                // Start or restart from any state; a coincident byte is dropped.
                state_q <= StLoad;
                count_q <= '0;
                idx_q   <= '0;
                word_q  <= '0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StLoad: begin
                        if (i_rx_valid) begin
                            if (count_q == CNT_FULL) begin
                                state_q <= StError;
                                busy_q  <= 1'b0;
                                error_q <= 1'b1;
                            end else begin
                                we_q    <= 1'b1;
                                wdata_q <= MEM_SIZE'(i_rx_data);
                                waddr_q <= count_q[DIR_ADDR_SIZE-1:0];
                                count_q <= count_q + CNT_ONE;
                                word_q  <= {word_q[15:0], i_rx_data};
                                idx_q   <= idx_q + IDX_ONE;
                                if ((&idx_q) && ({word_q, i_rx_data} == HALT_WORD)) begin
                                    state_q <= StDone;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                        end else if (timeout) begin
                            state_q <= StError;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                    StIdle, StDone, StError: begin
                        // Hold until i_start; bytes are ignored.
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_mem_enable       = busy_q;
    assign o_mem_write_enable = we_q;
    assign o_mem_write_data   = wdata_q;
    assign o_mem_write_addr   = waddr_q;
    assign o_byte_count       = count_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_error            = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: self-checking bench for inst_loader. A program-level model
// (list of bytes received, current mode) predicts the outputs, which are
// compared on every falling edge; literal expectations pin key points.
module tb_inst_loader;

    localparam int ENTRIES = 256;

    logic        i_clock    = 1'b0;
    logic        i_reset    = 1'b1;
    logic        i_start    = 1'b0;
    logic [7:0]  i_rx_data  = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_mem_enable;
    logic        o_mem_write_enable;
    logic [7:0]  o_mem_write_data;
    logic [7:0]  o_mem_write_addr;
    logic [8:0]  o_byte_count;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    inst_loader #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_rx_data          (i_rx_data),
        .i_rx_valid         (i_rx_valid),
        .o_mem_enable       (o_mem_enable),
        .o_mem_write_enable (o_mem_write_enable),
        .o_mem_write_data   (o_mem_write_data),
        .o_mem_write_addr   (o_mem_write_addr),
        .o_byte_count       (o_byte_count),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_error            (o_error)
    );

    always #5 i_clock = ~i_clock;

    typedef enum int {MIdle, MLoad, MDone, MError} mode_t;

    int         checks   = 0;
    int         errors   = 0;
    int         n_writes = 0;
    bit         chk_en   = 1'b0;
    mode_t      m_mode   = MIdle;
    logic [7:0] prog[$];
    logic       m_we     = 1'b0;
    int         m_addr   = 0;
    logic [7:0] m_data   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = MIdle;
        prog.delete();
        m_we = 1'b0;
    endfunction

    // Effect of one clock edge given the inputs applied before it.
    function automatic void model_step(input bit s, input bit v, input logic [7:0] d);
        logic [31:0] w;
        int          n;
        m_we = 1'b0;
        if (s) begin
            m_mode = MLoad;
            prog.delete();
        end else if (m_mode == MLoad && v) begin
            if (prog.size() == ENTRIES) begin
                m_mode = MError;
            end else begin
                m_we   = 1'b1;
                m_addr = prog.size();
                m_data = d;
                prog.push_back(d);
                n = prog.size();
                if (n % 4 == 0) begin
                    w = {prog[n-4], prog[n-3], prog[n-2], prog[n-1]};
                    if (w == 32'hFFFF_FFFF) m_mode = MDone;
                end
            end
        end
    endfunction

    always @(negedge i_clock) begin
        if (chk_en) begin
            check("write_enable", 32'(o_mem_write_enable), 32'(m_we));
            check("byte_count", 32'(o_byte_count), prog.size());
            check("busy", 32'(o_busy), 32'(m_mode == MLoad));
            check("mem_enable", 32'(o_mem_enable), 32'(m_mode == MLoad));
            check("done", 32'(o_done), 32'(m_mode == MDone));
            check("error", 32'(o_error), 32'(m_mode == MError));
            if (m_we) begin
                check("write_addr", 32'(o_mem_write_addr), m_addr);
                check("write_data", 32'(o_mem_write_data), 32'(m_data));
            end
            if (o_mem_write_enable) n_writes++;
        end
    end

    task automatic cyc(input bit s, input bit v, input logic [7:0] d);
        @(negedge i_clock);
        i_start    = s;
        i_rx_valid = v;
        i_rx_data  = d;
        @(posedge i_clock);
        model_step(s, v, d);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(o_mem_write_enable), 0);
        check({tag, "_data"}, 32'(o_mem_write_data), 0);
        check({tag, "_addr"}, 32'(o_mem_write_addr), 0);
        check({tag, "_count"}, 32'(o_byte_count), 0);
        check({tag, "_en"}, 32'(o_mem_enable), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_error"}, 32'(o_error), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] normal[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] misal[8]  = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

        #12;
        check_all_zero("reset");
        @(negedge i_clock);
        i_reset = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Bytes in IDLE are ignored.
        cyc(1'b0, 1'b1, 8'h33);
        check("idle_ignore_count", 32'(o_byte_count), 0);

        // Normal load ending in HALT.
        cyc(1'b1, 1'b0, 8'h00);
        check("start_busy", 32'(o_busy), 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, normal[i]);
        check("halt_we", 32'(o_mem_write_enable), 1);
        check("halt_addr", 32'(o_mem_write_addr), 7);
        check("halt_data", 32'(o_mem_write_data), 32'hFF);
        check("halt_done", 32'(o_done), 1);
        check("halt_busy", 32'(o_busy), 0);
        check("halt_count", 32'(o_byte_count), 8);
        cyc(1'b0, 1'b1, 8'h11);
        check("done_ignore_count", 32'(o_byte_count), 8);
        check("done_ignore_we", 32'(o_mem_write_enable), 0);

        // FF run straddling a word boundary is not HALT.
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, misal[i]);
        check("misal_count", 32'(o_byte_count), 8);
        check("misal_busy", 32'(o_busy), 1);
        check("misal_done", 32'(o_done), 0);

        // Restart mid-load.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 8'h02);
        cyc(1'b0, 1'b1, 8'h03);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'hAA);
        check("restart_addr", 32'(o_mem_write_addr), 0);
        check("restart_data", 32'(o_mem_write_data), 32'hAA);
        check("restart_count", 32'(o_byte_count), 1);

        // Start and byte together: start wins, byte dropped.
        cyc(1'b1, 1'b1, 8'h55);
        check("prio_count", 32'(o_byte_count), 0);
        check("prio_we", 32'(o_mem_write_enable), 0);
        check("prio_busy", 32'(o_busy), 1);
        n_writes = 0;

        // Fill memory, then overflow.
        for (int i = 0; i < ENTRIES; i++) cyc(1'b0, 1'b1, 8'(i) & 8'h7F);
        check("full_addr", 32'(o_mem_write_addr), 255);
        check("full_count", 32'(o_byte_count), 256);
        check("full_busy", 32'(o_busy), 1);
        cyc(1'b0, 1'b1, 8'h42);
        check("ovf_we", 32'(o_mem_write_enable), 0);
        check("ovf_error", 32'(o_error), 1);
        check("ovf_busy", 32'(o_busy), 0);
        check("ovf_count", 32'(o_byte_count), 256);
        cyc(1'b0, 1'b0, 8'h00);
        check("ovf_writes", n_writes, 256);

        // Asynchronous reset with a write strobe in flight.
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h12);
        cyc(1'b0, 1'b1, 8'h34);
        check("pre_reset_we", 32'(o_mem_write_enable), 1);
        #2;
        i_reset = 1'b1;
        #1;
        model_reset();
        check_all_zero("async_reset");
        @(negedge i_clock);
        i_reset = 1'b0;
        cyc(1'b0, 1'b1, 8'h77);
        check("post_reset_busy", 32'(o_busy), 0);
        check("post_reset_we", 32'(o_mem_write_enable), 0);

`ifdef INST_LOADER_TIMEOUT_EN
        chk_en = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 8'h00);
        check("timeout_early", 32'(o_error), 0);
        cyc(1'b0, 1'b0, 8'h00);
        check("timeout_error", 32'(o_error), 1);
        check("timeout_busy", 32'(o_busy), 0);
`endif

        cyc(1'b0, 1'b0, 8'h00);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
